// File: rtl/bus_fifo_pkg.sv
// Shared types and constants for the bus_fifo_port mailbox peripheral.
package bus_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS read bits
    localparam int unsigned STATUS_RX_NONEMPTY = 0;
    localparam int unsigned STATUS_TX_NONFULL  = 1;
    localparam int unsigned STATUS_OVERFLOW    = 2;
    localparam int unsigned STATUS_UNDERRUN    = 3;

    // STATUS write bits
    localparam int unsigned STATUS_CLR_FLAGS   = 0;
    localparam int unsigned STATUS_FLUSH       = 1;

    localparam logic [7:0] FORCED_READ_VALUE = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; head is presented on dout, forced to zero when empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push_c;
    logic             do_pop_c;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push_c = push && !full && !flush;
    assign do_pop_c  = pop && !empty && !flush;
    assign dout      = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; flush outranks any push or pop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push_c && !do_pop_c) begin
                count <= count + CNT_W'(1);
            end else if (do_pop_c && !do_push_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/bus_fifo_port.sv
// 8088 I/O-mapped mailbox: CPU writes feed a TX FIFO, CPU reads drain an RX FIFO,
// with bounded wait states while a data access is blocked.
module bus_fifo_port
    import bus_fifo_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ALE,
    input  logic                  CS,
    input  logic                  RD,
    input  logic                  WR,
    input  logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [7:0]            Data,
    output logic                  READY,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);
    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t           state;
    state_t           state_n;
    logic             sel;
    logic             sel_n;
    logic             cs_q;
    logic             cs_n;
    logic             op_rd;
    logic             op_rd_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [7:0]       rdata;
    logic [7:0]       rdata_n;
    logic             ready_n;
    logic             overflow;
    logic             overflow_n;
    logic             underrun;
    logic             underrun_n;

    logic             rx_full;
    logic             rx_empty;
    logic             tx_full;
    logic             tx_empty;
    logic [7:0]       rx_head;
    logic             rx_pop_c;
    logic             tx_push_c;
    logic             flush_c;
    logic             commit_c;
    logic             force_c;
    logic             is_read_c;
    logic             avail_c;
    logic [7:0]       status_c;
    logic             unused_addr_c;

    assign unused_addr_c = ^Address[ADDR_WIDTH-1:1];

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .flush   (flush_c),
        .push    (rx_valid && rx_ready),
        .din     (rx_data),
        .pop     (rx_pop_c),
        .dout    (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .flush   (flush_c),
        .push    (tx_push_c),
        .din     (Data),
        .pop     (tx_valid && tx_ready),
        .dout    (tx_data),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    // Direction is taken live on the first strobe edge, then held for the wait phase.
    assign is_read_c = (state == ACCESS) ? !RD : op_rd;
    assign avail_c   = (sel == REG_STATUS) || (is_read_c ? !rx_empty : !tx_full);

    always_comb begin
        status_c                     = '0;
        status_c[STATUS_RX_NONEMPTY] = !rx_empty;
        status_c[STATUS_TX_NONFULL]  = !tx_full;
        status_c[STATUS_OVERFLOW]    = overflow;
        status_c[STATUS_UNDERRUN]    = underrun;
    end

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        cs_n       = cs_q;
        op_rd_n    = op_rd;
        cnt_n      = cnt;
        rdata_n    = rdata;
        ready_n    = READY;
        overflow_n = overflow;
        underrun_n = underrun;
        rx_pop_c   = 1'b0;
        tx_push_c  = 1'b0;
        flush_c    = 1'b0;
        commit_c   = 1'b0;
        force_c    = 1'b0;

        case (state)
            IDLE: begin
                if (ALE && CS) begin
                    state_n = ADDR;
                    sel_n   = Address[0];
                    cs_n    = 1'b1;
                end
            end
            ADDR: begin
                if (!ALE) begin
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (!RD || !WR) begin
                    op_rd_n = !RD;
                    if (avail_c) begin
                        commit_c = 1'b1;
                        state_n  = DONE;
                    end else begin
                        ready_n = 1'b0;
                        cnt_n   = '0;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n = cnt + CNT_W'(1);
                if (avail_c) begin
                    commit_c = 1'b1;
                    ready_n  = 1'b1;
                    state_n  = DONE;
                end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
                    force_c = 1'b1;
                    ready_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                // An ALE here means the previous cycle never closed: restart on the new address.
                if (ALE) begin
                    state_n = CS ? ADDR : IDLE;
                    sel_n   = Address[0];
                    cs_n    = CS;
                end else if (RD && WR) begin
                    state_n = IDLE;
                    cs_n    = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                cs_n    = 1'b0;
            end
        endcase

        if (commit_c) begin
            if (is_read_c) begin
                if (sel == REG_DATA) begin
                    rx_pop_c = 1'b1;
                    rdata_n  = rx_head;
                end else begin
                    rdata_n = status_c;
                end
            end else if (sel == REG_DATA) begin
                tx_push_c = 1'b1;
            end else begin
                if (Data[STATUS_CLR_FLAGS]) begin
                    overflow_n = 1'b0;
                    underrun_n = 1'b0;
                end
                flush_c = Data[STATUS_FLUSH];
            end
        end

        if (force_c) begin
            if (op_rd) begin
                rdata_n    = FORCED_READ_VALUE;
                underrun_n = 1'b1;
            end else begin
                overflow_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            sel      <= REG_DATA;
            cs_q     <= 1'b0;
            op_rd    <= 1'b0;
            cnt      <= '0;
            rdata    <= '0;
            READY    <= 1'b1;
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            cs_q     <= cs_n;
            op_rd    <= op_rd_n;
            cnt      <= cnt_n;
            rdata    <= rdata_n;
            READY    <= ready_n;
            overflow <= overflow_n;
            underrun <= underrun_n;
        end
    end

    assign Data = (state == DONE && !RD && cs_q) ? rdata : 8'hzz;

endmodule

// File: tb/tb_bus_fifo_port.sv
// Randomized and directed bench for bus_fifo_port against a queue-based mailbox model.
module tb_bus_fifo_port;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AW       = 16;
    localparam int unsigned MAX_WAIT = 8;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          ALE = 1'b0;
    logic          CS = 1'b0;
    logic          RD = 1'b1;
    logic          WR = 1'b1;
    logic [AW-1:0] Address = '0;
    wire  [7:0]    Data;
    logic          READY;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;

    logic [7:0]    data_drv = '0;
    logic          data_oe = 1'b0;

    logic [7:0]    rx_q[$];
    logic [7:0]    tx_q[$];
    bit            m_ovf;
    bit            m_udr;
    int            errors = 0;
    int            checks = 0;

    assign Data = data_oe ? data_drv : 8'hzz;

    // A released bus reads back as all zeros.
    for (genvar i = 0; i < 8; i++) begin : g_pd
        pulldown (Data[i]);
    end

    always #5 CLK = ~CLK;

    bus_fifo_port #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .ALE      (ALE),
        .CS       (CS),
        .RD       (RD),
        .WR       (WR),
        .Address  (Address),
        .Data     (Data),
        .READY    (READY),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    function automatic logic [7:0] status_exp();
        return {4'b0000, m_udr, m_ovf, tx_q.size() < DEPTH, rx_q.size() > 0};
    endfunction

    task automatic push_rx(input logic [7:0] b);
        logic exp_rdy;
        @(negedge CLK);
        exp_rdy = (rx_q.size() < DEPTH);
        checks++;
        if (rx_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rx_ready: got %b expected %b", rx_ready, exp_rdy);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        rx_valid = 1'b0;
        if (exp_rdy) rx_q.push_back(b);
    endtask

    task automatic pop_tx();
        logic       exp_v;
        logic [7:0] exp_d;
        @(negedge CLK);
        exp_v = (tx_q.size() > 0);
        exp_d = exp_v ? tx_q[0] : 8'h00;
        checks++;
        if (tx_valid !== exp_v || tx_data !== exp_d) begin
            errors++;
            $display("FAIL tx_head: got v=%b d=%h expected v=%b d=%h", tx_valid, tx_data, exp_v, exp_d);
        end
        tx_ready = 1'b1;
        @(negedge CLK);
        tx_ready = 1'b0;
        if (exp_v) void'(tx_q.pop_front());
    endtask

    // One CPU bus cycle; prod_k >= 0 offers a producer byte on that wait clock (0 = strobe edge).
    task automatic bus_cycle(input bit is_read, input bit sel, input bit cs, input logic [7:0] wdata,
                             input int prod_k, input logic [7:0] prod_val, input bit cons,
                             input int hold, output logic [7:0] rdata, output int waits);
        int guard;
        @(negedge CLK);
        ALE     = 1'b1;
        CS      = cs;
        Address = AW'($urandom);
        Address[0] = sel;
        @(negedge CLK);
        ALE = 1'b0;
        CS  = 1'b0;
        @(negedge CLK);
        if (is_read) begin
            RD = 1'b0;
        end else begin
            WR       = 1'b0;
            data_drv = wdata;
            data_oe  = 1'b1;
        end
        if (prod_k == 0) begin
            rx_valid = 1'b1;
            rx_data  = prod_val;
        end
        if (cons) tx_ready = 1'b1;
        waits = 0;
        guard = 0;
        @(negedge CLK);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        while (READY !== 1'b1 && guard < 4 * MAX_WAIT) begin
            waits++;
            if (prod_k == waits) begin
                rx_valid = 1'b1;
                rx_data  = prod_val;
            end
            @(negedge CLK);
            rx_valid = 1'b0;
            guard++;
        end
        if (guard >= 4 * MAX_WAIT) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: READY still %b after %0d clocks, required 1", READY, guard);
        end
        rdata = Data;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            checks++;
            if (Data !== rdata || READY !== 1'b1) begin
                errors++;
                $display("FAIL hold_data: got %h ready=%b expected %h ready=1", Data, READY, rdata);
            end
        end
        RD      = 1'b1;
        WR      = 1'b1;
        data_oe = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        int         w;
        checks++;
        if (READY !== 1'b1 || Data !== 8'h00 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b data=%h rx_ready=%b tx_valid=%b tx_data=%h expected 1 00 1 0 00",
                     READY, Data, rx_ready, tx_valid, tx_data);
        end
        push_rx(8'h5A);
        @(negedge CLK);
        ALE = 1'b1; CS = 1'b1; Address = '0;
        @(negedge CLK);
        ALE = 1'b0; CS = 1'b0;
        @(negedge CLK);
        RD = 1'b0;
        @(negedge CLK);
        checks++;
        if (Data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_pre_drive: got %h expected 5a", Data);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if (Data !== 8'h00 || READY !== 1'b1 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_access: got data=%h ready=%b rx_ready=%b expected 00 1 1", Data, READY, rx_ready);
        end
        @(negedge CLK);
        RD = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        rx_q.delete();
        tx_q.delete();
        m_ovf = 0;
        m_udr = 0;
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL reset_status: got %h expected 02", rd);
        end
    endtask

    task automatic test_rx_read();
        logic [7:0] rd;
        int         w;
        logic [7:0] exp_vals[2];
        exp_vals[0] = 8'h3C;
        exp_vals[1] = 8'hA5;
        push_rx(8'h3C);
        push_rx(8'hA5);
        for (int i = 0; i < 2; i++) begin
            bus_cycle(1, 0, 1, 8'h00, -1, 8'h00, 0, 3, rd, w);
            checks++;
            if (rd !== exp_vals[i] || w !== 0) begin
                errors++;
                $display("FAIL rx_read%0d: got %h waits=%0d expected %h waits=0", i, rd, w, exp_vals[i]);
            end
            void'(rx_q.pop_front());
        end
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd[0] !== 1'b0) begin
            errors++;
            $display("FAIL rx_read_status: got b0=%b expected 0", rd[0]);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] rd;
        int         w;
        bus_cycle(1, 0, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'hFF || w !== MAX_WAIT) begin
            errors++;
            $display("FAIL underrun_read: got %h waits=%0d expected ff waits=%0d", rd, w, MAX_WAIT);
        end
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h0A) begin
            errors++;
            $display("FAIL underrun_status: got %h expected 0a", rd);
        end
        bus_cycle(0, 1, 1, 8'h01, -1, 8'h00, 0, 0, rd, w);
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL clear_status: got %h expected 02", rd);
        end
    endtask

    task automatic test_late_producer();
        logic [7:0] rd;
        int         w;
        bus_cycle(1, 0, 1, 8'h00, 3, 8'h55, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h55 || w !== 4) begin
            errors++;
            $display("FAIL late_producer: got %h waits=%0d expected 55 waits=4", rd, w);
        end
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL late_status: got %h expected 02", rd);
        end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] rd;
        int         w;
        int         exp_w;
        for (int i = 0; i <= DEPTH; i++) begin
            exp_w = (tx_q.size() < DEPTH) ? 0 : MAX_WAIT;
            bus_cycle(0, 0, 1, 8'(i), -1, 8'h00, 0, 0, rd, w);
            checks++;
            if (w !== exp_w) begin
                errors++;
                $display("FAIL tx_write%0d: got waits=%0d expected %0d", i, w, exp_w);
            end
            if (exp_w == 0) tx_q.push_back(8'(i));
            else m_ovf = 1;
        end
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h04) begin
            errors++;
            $display("FAIL overflow_status: got %h expected 04", rd);
        end
        for (int i = 0; i <= DEPTH; i++) pop_tx();
        bus_cycle(0, 1, 1, 8'h01, -1, 8'h00, 0, 0, rd, w);
        m_ovf = 0;
        // Pointers have wrapped once; confirm ordering still holds.
        for (int i = 0; i < 3; i++) begin
            bus_cycle(0, 0, 1, 8'hC0 + 8'(i), -1, 8'h00, 0, 0, rd, w);
            tx_q.push_back(8'hC0 + 8'(i));
        end
        for (int i = 0; i < 3; i++) pop_tx();
    endtask

    task automatic test_cs_inert();
        logic [7:0] rd;
        int         w;
        push_rx(8'h77);
        bus_cycle(1, 0, 0, 8'h00, -1, 8'h00, 0, 2, rd, w);
        checks++;
        if (rd !== 8'h00 || w !== 0) begin
            errors++;
            $display("FAIL cs_inert_read: got data=%h waits=%0d expected 00 waits=0", rd, w);
        end
        bus_cycle(0, 0, 0, 8'h99, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL cs_inert_write: got tx_valid=%b expected 0", tx_valid);
        end
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== status_exp()) begin
            errors++;
            $display("FAIL cs_inert_status: got %h expected %h", rd, status_exp());
        end
        bus_cycle(1, 0, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h77) begin
            errors++;
            $display("FAIL cs_inert_data: got %h expected 77", rd);
        end
        void'(rx_q.pop_front());
    endtask

    task automatic test_flush_with_push();
        logic [7:0] rd;
        int         w;
        push_rx(8'h11);
        push_rx(8'h22);
        bus_cycle(0, 0, 1, 8'h33, -1, 8'h00, 0, 0, rd, w);
        bus_cycle(0, 0, 1, 8'h44, -1, 8'h00, 0, 0, rd, w);
        bus_cycle(0, 1, 1, 8'h02, 0, 8'hEE, 0, 0, rd, w);
        rx_q.delete();
        tx_q.delete();
        @(negedge CLK);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_local: got tx_valid=%b rx_ready=%b expected 0 1", tx_valid, rx_ready);
        end
        bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
        checks++;
        if (rd !== 8'h02) begin
            errors++;
            $display("FAIL flush_status: got %h expected 02", rd);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd;
        logic [7:0] pv;
        logic [7:0] exp_d;
        int         w;
        int         exp_w;
        int         op;
        bit         conc;
        bit         acc;
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            pv = 8'($urandom);
            if (op <= 2) begin
                push_rx(pv);
            end else if (op == 3) begin
                pop_tx();
            end else if (op <= 5) begin
                if (rx_q.size() == 0 && $urandom_range(0, 3) != 0) begin
                    push_rx(pv);
                end else begin
                    conc  = (rx_q.size() > 0) && ($urandom_range(0, 1) == 1);
                    acc   = conc && (rx_q.size() < DEPTH);
                    exp_d = (rx_q.size() > 0) ? rx_q[0] : 8'hFF;
                    exp_w = (rx_q.size() > 0) ? 0 : MAX_WAIT;
                    bus_cycle(1, 0, 1, 8'h00, conc ? 0 : -1, pv, 0, 0, rd, w);
                    checks++;
                    if (rd !== exp_d || w !== exp_w) begin
                        errors++;
                        $display("FAIL rand_read%0d: got %h waits=%0d expected %h waits=%0d", n, rd, w, exp_d, exp_w);
                    end
                    if (rx_q.size() > 0) void'(rx_q.pop_front());
                    else m_udr = 1;
                    if (acc) rx_q.push_back(pv);
                end
            end else if (op <= 7) begin
                conc  = (tx_q.size() > 0) && (tx_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
                exp_w = (tx_q.size() < DEPTH) ? 0 : MAX_WAIT;
                bus_cycle(0, 0, 1, pv, -1, 8'h00, conc, 0, rd, w);
                checks++;
                if (w !== exp_w) begin
                    errors++;
                    $display("FAIL rand_write%0d: got waits=%0d expected %0d", n, w, exp_w);
                end
                if (conc) void'(tx_q.pop_front());
                if (exp_w == 0) tx_q.push_back(pv);
                else m_ovf = 1;
            end else if (op == 8) begin
                bus_cycle(1, 1, 1, 8'h00, -1, 8'h00, 0, 0, rd, w);
                checks++;
                if (rd !== status_exp()) begin
                    errors++;
                    $display("FAIL rand_status%0d: got %h expected %h", n, rd, status_exp());
                end
            end else begin
                pv = ($urandom_range(0, 7) == 0) ? 8'h03 : 8'h01;
                bus_cycle(0, 1, 1, pv, -1, 8'h00, 0, 0, rd, w);
                m_ovf = 0;
                m_udr = 0;
                if (pv[1]) begin
                    rx_q.delete();
                    tx_q.delete();
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        test_reset();
        test_rx_read();
        test_underrun();
        test_late_producer();
        test_tx_overflow();
        test_cs_inert();
        test_flush_with_push();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
